// File: rtl/dp_ram_core.sv
// Dual-port RAM with post-reset hardware clear, port-A-wins
// write collisions and a saturating collision counter.
module dp_ram_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en_a,
    input  logic [$clog2(DEPTH)-1:0] addr_a,
    input  logic [WIDTH-1:0]         data_in_a,
    output logic [WIDTH-1:0]         data_out_a,
    input  logic                     w_en_b,
    input  logic [$clog2(DEPTH)-1:0] addr_b,
    input  logic [WIDTH-1:0]         data_in_b,
    output logic [WIDTH-1:0]         data_out_b,
    output logic                     busy,
    output logic                     collision,
    output logic [CNT_W-1:0]         collision_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    clr_ptr_q;
    logic             busy_q;
    logic             coll_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dout_a_q;
    logic [WIDTH-1:0] dout_b_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             ready;
    logic             coll_d;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] dout_a_d;
    logic [WIDTH-1:0] dout_b_d;
    logic             mem_we_a;
    logic [AW-1:0]    mem_addr_a;
    logic [WIDTH-1:0] mem_wdata_a;
    logic             mem_we_b;

    always_comb begin
        ready       = (state_q == READY);
        coll_d      = ready && w_en_a && w_en_b && (addr_a == addr_b);
        // Write port A doubles as the clear port while in INIT.
        mem_we_a    = ready ? w_en_a : 1'b1;
        mem_addr_a  = ready ? addr_a : clr_ptr_q;
        mem_wdata_a = ready ? data_in_a : '0;
        mem_we_b    = ready && w_en_b && !coll_d;

        dout_a_d = dout_a_q;
        dout_b_d = dout_b_q;
        if (ready) begin
            dout_a_d = w_en_a ? data_in_a : mem_q[addr_a];
            if (coll_d) begin
                dout_b_d = data_in_a;
            end else begin
                dout_b_d = w_en_b ? data_in_b : mem_q[addr_b];
            end
        end

        cnt_d = cnt_q;
        if (coll_d && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            coll_q    <= 1'b0;
            cnt_q     <= '0;
            dout_a_q  <= '0;
            dout_b_q  <= '0;
        end else begin
            coll_q   <= coll_d;
            cnt_q    <= cnt_d;
            dout_a_q <= dout_a_d;
            dout_b_q <= dout_b_d;
            unique case (state_q)
                INIT: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    state_q <= READY;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    // While rst is held the FSM sits in INIT at pointer 0, so the
    // only write that can land is a harmless zero to word 0.
    always_ff @(posedge clk) begin
        if (mem_we_a) begin
            mem_q[mem_addr_a] <= mem_wdata_a;
        end
        if (mem_we_b) begin
            mem_q[addr_b] <= data_in_b;
        end
    end

    assign data_out_a    = dout_a_q;
    assign data_out_b    = dout_b_q;
    assign busy          = busy_q;
    assign collision     = coll_q;
    assign collision_cnt = cnt_q;

endmodule
